// File: rtl/rfft_seq_ctrl_if.sv
// Handshake and address bus between the real-FFT sequencer, top-level control
// and the butterfly datapath / sample RAM / twiddle ROM.
interface rfft_seq_ctrl_if #(
  parameter int unsigned LOG2N = 7
);
  localparam int unsigned AW = LOG2N;
  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned SW = ($clog2(LOG2N) > 1) ? $clog2(LOG2N) : 1;

  logic          start;
  logic          inverse;
  logic          stall;
  logic          busy;
  logic          done;
  logic [SW-1:0] stage;
  logic          rd_en;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [KW-1:0] tw_addr;
  logic          tw_conj;
  logic          wr_en;
  logic [AW-1:0] wr_addr_a;
  logic [AW-1:0] wr_addr_b;

  modport master (
    input  start, inverse, stall,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr, tw_conj,
           wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start, inverse, stall,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr, tw_conj,
           wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/rfft_seq_ctrl.sv
// Stage/butterfly sequencer for an in-place radix-2 real FFT of N = 2^LOG2N
// points, with read issue, twiddle addressing and delayed write-back.
module rfft_seq_ctrl #(
  parameter int unsigned LOG2N  = 7,
  parameter int unsigned BF_LAT = 3
) (
  input  logic          Clk,
  input  logic          Reset_n,
  rfft_seq_ctrl_if.master bus
);
  localparam int unsigned AW = LOG2N;
  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned SW = ($clog2(LOG2N) > 1) ? $clog2(LOG2N) : 1;
  localparam int unsigned DW = ($clog2(BF_LAT) > 1) ? $clog2(BF_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          conj_q, conj_d;
  logic          issue_c;
  logic          accept_c;

  logic          busy_q, done_q;
  logic [SW-1:0] stage_out_q;
  logic          rd_en_q;
  logic [AW-1:0] rd_addr_a_q, rd_addr_b_q;
  logic [KW-1:0] tw_addr_q;
  logic          tw_conj_q;

  logic          pipe_v [BF_LAT];
  logic [AW-1:0] pipe_a [BF_LAT];
  logic [AW-1:0] pipe_b [BF_LAT];

  // Butterfly k of stage s: legs are span = 2^s apart inside groups of 2*span.
  int unsigned   sh_c;
  logic [AW-1:0] k_ext_c, span_c, pos_c, grp_c, addr_a_c, addr_b_c, tw_full_c;

  always_comb begin
    sh_c      = 32'(stage_q);
    k_ext_c   = AW'(k_q);
    span_c    = AW'(1) << sh_c;
    pos_c     = k_ext_c & (span_c - AW'(1));
    grp_c     = k_ext_c >> sh_c;
    addr_a_c  = (grp_c << (sh_c + 32'd1)) | pos_c;
    addr_b_c  = addr_a_c + span_c;
    tw_full_c = pos_c << (KW - sh_c);
  end

  // Next-state logic: issue one butterfly per unstalled RUN cycle, then drain.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    k_d      = k_q;
    dcnt_d   = dcnt_q;
    conj_d   = conj_q;
    issue_c  = 1'b0;
    accept_c = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_d  = RUN;
          stage_d  = '0;
          k_d      = '0;
          conj_d   = bus.inverse;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          issue_c = 1'b1;
          if (k_q == {KW{1'b1}}) begin
            state_d = DRAIN;
            dcnt_d  = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      DRAIN: begin
        if (dcnt_q == DW'(BF_LAT - 1)) begin
          if (stage_q == SW'(LOG2N - 1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + SW'(1);
            k_d     = '0;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      k_q         <= '0;
      dcnt_q      <= '0;
      conj_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stage_out_q <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q   <= '0;
      tw_conj_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      k_q         <= k_d;
      dcnt_q      <= dcnt_d;
      conj_q      <= conj_d;
      busy_q      <= (state_q == RUN) || (state_q == DRAIN);
      done_q      <= (state_q == DONE);
      if (issue_c)       stage_out_q <= stage_q;
      else if (accept_c) stage_out_q <= '0;
      rd_en_q     <= issue_c;
      rd_addr_a_q <= issue_c ? addr_a_c : '0;
      rd_addr_b_q <= issue_c ? addr_b_c : '0;
      tw_addr_q   <= issue_c ? tw_full_c[KW-1:0] : '0;
      tw_conj_q   <= issue_c & conj_q;
    end
  end

  // Write-back delay line; addresses are already zero whenever rd_en was low.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < BF_LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_a[i] <= '0;
        pipe_b[i] <= '0;
      end
    end else begin
      pipe_v[0] <= rd_en_q;
      pipe_a[0] <= rd_addr_a_q;
      pipe_b[0] <= rd_addr_b_q;
      for (int unsigned i = 1; i < BF_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
        pipe_b[i] <= pipe_b[i-1];
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = stage_out_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = rd_addr_a_q;
  assign bus.rd_addr_b = rd_addr_b_q;
  assign bus.tw_addr   = tw_addr_q;
  assign bus.tw_conj   = tw_conj_q;
  assign bus.wr_en     = pipe_v[BF_LAT-1];
  assign bus.wr_addr_a = pipe_a[BF_LAT-1];
  assign bus.wr_addr_b = pipe_b[BF_LAT-1];
endmodule

// File: tb/tb_rfft_seq_ctrl.sv
// Bench for rfft_seq_ctrl: an 8-point and a 128-point instance checked cycle by
// cycle against a schedule built from butterfly loops over (stage, group, pos).
module tb_rfft_seq_ctrl;
  localparam int MAXT = 2048;
  localparam int LAT  = 3;

  logic clk = 1'b0;
  logic rst3, rst7;
  always #5 clk = ~clk;

  rfft_seq_ctrl_if #(.LOG2N(3)) if3 ();
  rfft_seq_ctrl_if #(.LOG2N(7)) if7 ();

  rfft_seq_ctrl #(.LOG2N(3), .BF_LAT(LAT)) dut3 (.Clk(clk), .Reset_n(rst3), .bus(if3));
  rfft_seq_ctrl #(.LOG2N(7), .BF_LAT(LAT)) dut7 (.Clk(clk), .Reset_n(rst7), .bus(if7));

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] s_rd, s_a, s_b, s_tw, s_conj, s_stage, s_wr, s_wa, s_wb, s_busy, s_done;

  bit st [MAXT];
  int e_rd [MAXT], e_a [MAXT], e_b [MAXT], e_tw [MAXT], e_stage [MAXT];
  int e_wr [MAXT], e_wa [MAXT], e_wb [MAXT];

  task automatic check(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, t, obs, exp);
    end
  endtask

  task automatic sample(input int sel);
    if (sel == 0) begin
      s_rd = 32'(if3.rd_en);   s_a = 32'(if3.rd_addr_a); s_b = 32'(if3.rd_addr_b);
      s_tw = 32'(if3.tw_addr); s_conj = 32'(if3.tw_conj); s_stage = 32'(if3.stage);
      s_wr = 32'(if3.wr_en);   s_wa = 32'(if3.wr_addr_a); s_wb = 32'(if3.wr_addr_b);
      s_busy = 32'(if3.busy);  s_done = 32'(if3.done);
    end else begin
      s_rd = 32'(if7.rd_en);   s_a = 32'(if7.rd_addr_a); s_b = 32'(if7.rd_addr_b);
      s_tw = 32'(if7.tw_addr); s_conj = 32'(if7.tw_conj); s_stage = 32'(if7.stage);
      s_wr = 32'(if7.wr_en);   s_wa = 32'(if7.wr_addr_a); s_wb = 32'(if7.wr_addr_b);
      s_busy = 32'(if7.busy);  s_done = 32'(if7.done);
    end
  endtask

  task automatic drive(input int sel, input bit start, input bit inv, input bit stall);
    if (sel == 0) begin if3.start = start; if3.inverse = inv; if3.stall = stall; end
    else          begin if7.start = start; if7.inverse = inv; if7.stall = stall; end
  endtask

  task automatic check_zero(input int sel, input int t);
    sample(sel);
    check("rst_rd_en", t, s_rd, 0);   check("rst_wr_en", t, s_wr, 0);
    check("rst_busy", t, s_busy, 0);  check("rst_done", t, s_done, 0);
    check("rst_conj", t, s_conj, 0);  check("rst_stage", t, s_stage, 0);
    check("rst_rd_a", t, s_a, 0);     check("rst_rd_b", t, s_b, 0);
    check("rst_tw", t, s_tw, 0);
    check("rst_wr_a", t, s_wa, 0);    check("rst_wr_b", t, s_wb, 0);
  endtask

  // mode 0: no stall, 1: stall at edges 2-3, 2: random stall with pct percent
  task automatic run(input int sel, input int mode, input int pct, input bit inv, input int abort_at);
    int L, H, t, t_done, n_rd, first_done;
    bit ms;
    L = (sel == 0) ? 3 : 7;
    H = 1 << (L - 1);
    n_rd = 0;
    first_done = -1;
    for (int i = 0; i < MAXT; i++) begin
      st[i] = (mode == 1) ? (i == 2 || i == 3) :
              (mode == 2) ? ($urandom_range(99) < 32'(pct)) : 1'b0;
      e_rd[i] = 0; e_a[i] = 0; e_b[i] = 0; e_tw[i] = 0; e_stage[i] = 0;
      e_wr[i] = 0; e_wa[i] = 0; e_wb[i] = 0;
    end
    // Reference schedule: one butterfly per unstalled cycle, LAT idle cycles per stage.
    t = 1;
    for (int s = 0; s < L; s++) begin
      int span = 1 << s;
      for (int grp = 0; grp < H / span; grp++) begin
        for (int pos = 0; pos < span; pos++) begin
          while (st[t] && t < MAXT - 16) t++;
          e_rd[t] = 1;
          e_a[t] = grp * 2 * span + pos;
          e_b[t] = e_a[t] + span;
          e_tw[t] = pos * (H / span);
          e_stage[t] = s;
          e_wr[t+LAT] = 1; e_wa[t+LAT] = e_a[t]; e_wb[t+LAT] = e_b[t];
          t++;
        end
      end
      t += LAT;
    end
    t_done = t;

    @(negedge clk);
    drive(sel, 1'b1, inv, 1'b0);
    for (int c = 1; c <= t_done + 1; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        int p = c - 1;
        sample(sel);
        if (s_rd == 1) n_rd++;
        if (s_done == 1 && first_done < 0) first_done = p;
        check("busy", p, s_busy, 32'(p < t_done));
        check("done", p, s_done, 32'(p == t_done));
        check("rd_en", p, s_rd, 32'(e_rd[p]));
        if (e_rd[p] != 0) begin
          check("rd_addr_a", p, s_a, 32'(e_a[p]));
          check("rd_addr_b", p, s_b, 32'(e_b[p]));
          check("tw_addr", p, s_tw, 32'(e_tw[p]));
          check("tw_conj", p, s_conj, 32'(inv));
          check("stage", p, s_stage, 32'(e_stage[p]));
        end
        check("wr_en", p, s_wr, 32'(e_wr[p]));
        check("wr_addr_a", p, s_wa, 32'(e_wa[p]));
        check("wr_addr_b", p, s_wb, 32'(e_wb[p]));
        if (p == abort_at) return;
      end
      if (c <= t_done) begin
        ms = (c >= 2) && (c < t_done) && ($urandom_range(99) < 3);
        drive(sel, ms, ms ? 1'b1 : 1'($urandom_range(1)), st[c]);
      end else begin
        drive(sel, 1'b0, 1'b0, 1'b0);
      end
    end
    check("bf_count", t_done, 32'(n_rd), 32'(L * H));
    check("done_cycle", t_done, 32'(first_done), 32'(t_done));
  endtask

  initial begin
    rst3 = 1'b0;
    rst7 = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    #1;
    check_zero(0, 0);
    check_zero(1, 0);
    repeat (2) @(negedge clk);
    rst3 = 1'b1;
    rst7 = 1'b1;
    @(negedge clk);
    check_zero(0, 0);

    run(0, 0, 0, 1'b0, -1);
    run(0, 1, 0, 1'b0, -1);
    run(0, 0, 0, 1'b1, -1);
    for (int r = 0; r < 4; r++) run(0, 2, 30, 1'($urandom_range(1)), -1);

    // Async reset in stage 1 while writes are still in flight.
    run(0, 0, 0, 1'b1, 12);
    rst3 = 1'b0;
    #1;
    check_zero(0, 12);
    drive(0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sample(0);
      check("post_rst_wr_en", i, s_wr, 0);
      check("post_rst_busy", i, s_busy, 0);
    end
    run(0, 0, 0, 1'b0, -1);

    run(1, 0, 0, 1'b0, -1);
    run(1, 2, 20, 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
